// File: rtl/muldiv_unit.sv
// Shared sequential multiply/divide engine for the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide over one 2*WIDTH accumulator.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned AW    = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, ZDIV} state_t;

    state_t           state, state_n;
    logic [AW-1:0]    acc, acc_n;
    logic [WIDTH-1:0] opd, opd_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             is_div, is_div_n;
    logic             sa, sa_n, sb, sb_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n, dz_n;

    logic             signed_op, a_neg, b_neg, zdiv;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   msum, dtrial;
    logic [AW-1:0]    mul_step, div_step, prod_neg;
    logic [WIDTH-1:0] quo, rem;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= '0;
            opd      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            opd      <= opd_n;
            cnt      <= cnt_n;
            is_div   <= is_div_n;
            sa       <= sa_n;
            sb       <= sb_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
            div_zero <= dz_n;
        end
    end

    // Next-state, datapath step and result fix-up
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        opd_n    = opd;
        cnt_n    = cnt;
        is_div_n = is_div;
        sa_n     = sa;
        sb_n     = sb;
        hi_n     = hi;
        lo_n     = lo;
        done_n   = 1'b0;
        dz_n     = div_zero;

        signed_op = ~op[0];
        a_neg     = a[WIDTH-1] & signed_op;
        b_neg     = b[WIDTH-1] & signed_op;
        a_mag     = a_neg ? (~a + WIDTH'(1)) : a;
        b_mag     = b_neg ? (~b + WIDTH'(1)) : b;
        zdiv      = op[1] && (b == '0);

        // Multiply: add multiplicand into upper half when the low bit is set, then shift right
        msum     = {1'b0, acc[AW-1:WIDTH]} + {1'b0, opd & {WIDTH{acc[0]}}};
        mul_step = {msum, acc[WIDTH-1:1]};

        // Divide: trial-subtract divisor from the shifted partial remainder
        dtrial   = acc[AW-1:WIDTH-1] - {1'b0, opd};
        div_step = dtrial[WIDTH] ? {acc[AW-2:0], 1'b0}
                                 : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_neg = ~acc + AW'(1);
        quo      = acc[WIDTH-1:0];
        rem      = acc[AW-1:WIDTH];

        case (state)
            IDLE: begin
                if (start && !done) begin
                    is_div_n = op[1];
                    sa_n     = a_neg;
                    sb_n     = b_neg;
                    cnt_n    = '0;
                    dz_n     = 1'b0;
                    if (op[1]) begin
                        acc_n = {WIDTH'(0), (zdiv ? a : a_mag)};
                        opd_n = b_mag;
                    end else begin
                        acc_n = {WIDTH'(0), b_mag};
                        opd_n = a_mag;
                    end
                    state_n = zdiv ? ZDIV : CALC;
                end
            end
            CALC: begin
                acc_n = is_div ? div_step : mul_step;
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
            end
            FIX: begin
                if (is_div) begin
                    lo_n = (sa ^ sb) ? (~quo + WIDTH'(1)) : quo;
                    hi_n = sa ? (~rem + WIDTH'(1)) : rem;
                end else begin
                    {hi_n, lo_n} = (sa ^ sb) ? prod_neg : acc;
                end
                done_n  = 1'b1;
                state_n = IDLE;
            end
            ZDIV: begin
                hi_n    = acc[WIDTH-1:0];
                lo_n    = '1;
                dz_n    = 1'b1;
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, handshake corner cases,
// and a random sweep on 32- and 8-bit instances against an arithmetic model.
module tb_muldiv_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start, busy, done, div_zero;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;

    logic        start8, busy8, done8, div_zero8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(div_zero8)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on sign- or zero-extended operands
    function automatic void model(input int unsigned w, input logic [1:0] o,
                                  input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] mh, output logic [63:0] ml,
                                  output logic md);
        logic [63:0] mask;
        logic [63:0] p;
        longint      xs, ys;
        logic        sgn;
        mask = (64'd1 << w) - 64'd1;
        sgn  = ~o[0];
        xs   = (sgn && x[w-1]) ? longint'(x) - (longint'(1) << w) : longint'(x);
        ys   = (sgn && y[w-1]) ? longint'(y) - (longint'(1) << w) : longint'(y);
        md   = 1'b0;
        if (!o[1]) begin
            if (sgn) p = 64'(xs * ys);
            else     p = x * y;
            ml = p & mask;
            mh = (p >> w) & mask;
        end else if (y == 64'd0) begin
            md = 1'b1;
            mh = x;
            ml = mask;
        end else if (sgn) begin
            ml = 64'(xs / ys) & mask;
            mh = 64'(xs % ys) & mask;
        end else begin
            ml = x / y;
            mh = x % y;
        end
    endfunction

    // Launch one op; n counts edges with the start edge as 1; ends one cycle past done
    task automatic run32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] rh, output logic [31:0] rl,
                         output logic rd, output int n);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        rh = hi; rl = lo; rd = div_zero;
        @(posedge clock); #1;
    endtask

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] rh, output logic [7:0] rl,
                        output logic rd, output int n);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clock); #1;
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        rh = hi8; rl = lo8; rd = div_zero8;
        @(posedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[12];
        logic [31:0] rh, rl, h0, l0;
        logic [7:0]  rh8, rl8;
        logic        rd, held_ok;
        logic [63:0] mh, ml;
        logic        md;
        int          n;

        vt[0]  = '{2'b00, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
        vt[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vt[2]  = '{2'b10, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vt[3]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vt[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vt[5]  = '{2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        vt[6]  = '{2'b10, 32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 1'b0};
        vt[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vt[8]  = '{2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1};
        vt[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vt[10] = '{2'b11, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
        vt[11] = '{2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};

        reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz",   64'(div_zero), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset8_hilo", 64'({busy8, done8, div_zero8, hi8, lo8}), 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            run32(vt[i].op, vt[i].a, vt[i].b, rh, rl, rd, n);
            check($sformatf("vec%0d_hi", i), 64'(rh), 64'(vt[i].hi));
            check($sformatf("vec%0d_lo", i), 64'(rl), 64'(vt[i].lo));
            check($sformatf("vec%0d_dz", i), 64'(rd), 64'(vt[i].dz));
            check($sformatf("vec%0d_lat", i), 64'(n),
                  (vt[i].op[1] && vt[i].b == 32'd0) ? 64'd2 : 64'd34);
        end

        // div_zero set, then cleared by the next accepted start
        run32(2'b11, 32'h1234, 32'd0, rh, rl, rd, n);
        check("dz_set", 64'(div_zero), 64'd1);
        op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("dz_cleared", 64'(div_zero), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 200) begin @(posedge clock); #1; n++; end
        check("multu_2x3", {hi, lo}, 64'd6);
        @(posedge clock); #1;

        // Start during CALC ignored, hi/lo held, single-cycle done, start in done cycle ignored
        h0 = hi; l0 = lo; held_ok = 1'b1;
        op = 2'b00; a = 32'hFFFFFFF9; b = 32'd6; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            if (hi !== h0 || lo !== l0) held_ok = 1'b0;
            if (n == 5) begin op = 2'b11; a = 32'd100; b = 32'd200; start = 1'b1; end
            @(posedge clock); #1;
            start = 1'b0;
            n++;
        end
        check("hold_hilo", 64'(held_ok), 64'd1);
        check("ignore_lat", 64'(n), 64'd34);
        check("ignore_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);
        op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("start_in_done_ignored", 64'(busy), 64'd0);
        @(posedge clock); #1;
        start = 1'b0;
        check("back_to_back_accepted", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 200) begin @(posedge clock); #1; n++; end
        check("back_to_back_lat", 64'(n), 64'd34);
        check("back_to_back_res", {hi, lo}, 64'd81);
        @(posedge clock); #1;

        // Asynchronous reset in the middle of CALC
        op = 2'b01; a = 32'h12345678; b = 32'd9; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run32(2'b01, 32'd3, 32'd5, rh, rl, rd, n);
        check("after_reset_res", {rh, rl}, 64'd15);
        check("after_reset_lat", 64'(n), 64'd34);

        // 8-bit instance
        run8(2'b00, 8'h80, 8'h80, rh8, rl8, rd, n);
        check("w8_minmin", 64'({rh8, rl8}), 64'h4000);
        check("w8_lat", 64'(n), 64'd10);
        run8(2'b11, 8'h5A, 8'h00, rh8, rl8, rd, n);
        check("w8_zdiv", 64'({rd, rh8, rl8}), 64'h15AFF);
        check("w8_zdiv_lat", 64'(n), 64'd2);

        // Random sweep, 32-bit
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'h80000000;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            model(32, ro, 64'(ra), 64'(rb), mh, ml, md);
            run32(ro, ra, rb, rh, rl, rd, n);
            check($sformatf("rnd32_%0d op%0d %h/%h hilo", i, ro, ra, rb), {rh, rl}, {mh[31:0], ml[31:0]});
            check($sformatf("rnd32_%0d dz", i), 64'(rd), 64'(md));
        end

        // Random sweep, 8-bit
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            logic [7:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            model(8, ro, 64'(ra), 64'(rb), mh, ml, md);
            run8(ro, ra, rb, rh8, rl8, rd, n);
            check($sformatf("rnd8_%0d op%0d %h/%h hilo", i, ro, ra, rb), 64'({rh8, rl8}), 64'({mh[7:0], ml[7:0]}));
            check($sformatf("rnd8_%0d dz", i), 64'(rd), 64'(md));
            check($sformatf("rnd8_%0d lat", i), 64'(n), (ro[1] && rb == 8'd0) ? 64'd2 : 64'd10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
